// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read arbiter.
// Burst shape and AR protection encodings live here.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int          BURST_LEN    = 8;
  localparam logic [2:0]  ARSIZE_64    = 3'b011;
  localparam logic [1:0]  ARBURST_WRAP = 2'b10;
  localparam logic [2:0]  ARPROT_INSN  = 3'b100;
  localparam logic [2:0]  ARPROT_DATA  = 3'b000;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// Two-way round-robin picker.
// Contested requests go to the port not granted last time.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant; both requesting favours the other port
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between fetch (0) and load (1).
// One 8-beat wrap burst in flight; beats steered to owner.
module axi_read_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  output logic [1:0]            req_ready,
  output logic [1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [2:0]            resp_beat,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic                  proto_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   proto_q, proto_d;
  logic [2:0]             beat_q, beat_d;
  logic [ADDR_WIDTH-1:3]  addr_q, addr_d;
  logic [1:0]             grant;

  // single outstanding burst, so the returned ID carries no information
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  rr_arbiter2 u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign resp_data = m_axi_rdata;
  assign resp_beat = beat_q;
  assign proto_err = proto_q;

  // state and datapath registers; fetch wins the first contest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      proto_q <= 1'b0;
      beat_q  <= 3'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      proto_q <= proto_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
    end
  end

  // next state, AR drive and R steering
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    proto_d       = proto_q;
    beat_d        = beat_q;
    addr_d        = addr_q;
    req_ready     = 2'b00;
    resp_valid    = 2'b00;
    resp_last     = 1'b0;
    resp_err      = 1'b0;
    m_axi_arid    = '0;
    m_axi_araddr  = '0;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'd0;
    m_axi_arburst = 2'd0;
    m_axi_arlock  = 1'b0;
    m_axi_arcache = 4'd0;
    m_axi_arprot  = 3'd0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          owner_d   = grant[1];
          last_d    = grant[1];
          addr_d    = grant[1] ? req_addr1[ADDR_WIDTH-1:3]
                               : req_addr0[ADDR_WIDTH-1:3];
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi_arvalid = 1'b1;
        m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner_q};
        m_axi_araddr  = {addr_q, 3'b000};
        m_axi_arlen   = 8'(BURST_LEN - 1);
        m_axi_arsize  = ARSIZE_64;
        m_axi_arburst = ARBURST_WRAP;
        m_axi_arprot  = owner_q ? ARPROT_DATA : ARPROT_INSN;
        if (m_axi_arready) begin
          beat_d  = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          resp_valid = owner_q ? 2'b10 : 2'b01;
          resp_last  = m_axi_rlast;
          resp_err   = (m_axi_rresp != 2'b00);
          beat_d     = beat_q + 3'd1;
          // rlast must coincide exactly with the eighth beat
          if (m_axi_rlast != (beat_q == 3'(BURST_LEN - 1))) begin
            proto_d = 1'b1;
          end
          if (m_axi_rlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
